add_tree_acc: RTL
=================

# add_tree_acc

Parametrised, pipelined multi-lane signed adder with packet accumulation for the NPU datapath. It replaces the single-bit two-input adder. Each beat it reduces LANES signed operands through a registered binary adder tree. It accumulates the per-beat sums across a packet delimited by `in_last` and emits one total per packet over a valid/ready stream. It sits between the MAC array outputs and the writeback/requantise stage.

## Interface
- `LANES`, 8, operands per beat; power of two, ≥ 2
- `IN_W`, 8, width of each signed operand
- `ACC_W`, 24, width of the accumulator and result; must be ≥ IN_W + log2(LANES)
- `clk` input 1: single clock; all state on its rising edge
- `rst_n` input 1: reset, asynchronous assert, active-low
- `in_valid` input 1: input beat valid
- `in_ready` output 1: block accepts a beat this cycle
- `in_data` input LANES*IN_W: packed signed operands; lane k at bits [k*IN_W +: IN_W]
- `in_last` input 1: final beat of the current packet
- `out_valid` output 1: `out_sum` holds a packet total
- `out_ready` input 1: downstream accepts the total
- `out_sum` output ACC_W: signed packet total
- `out_ovf` output 1: accumulator overflow occurred within this packet

## Operation
- Acceptance: a beat is accepted when `in_valid && in_ready`.
- Global enable: `en = !out_valid || out_ready`. `in_ready = en`, combinational. Every pipeline register advances only when `en` = 1. On a stall, all stages, `acc`, `out_*` and the flags freeze.
- Tree:
  - S = log2(LANES) registered levels.
  - Level j holds LANES/2^(j+1) sums of width IN_W+j+1, sign-extended before each add. The tree sum is exact and never overflows.
  - Each level carries a valid bit and the `last` tag.
- Accumulate stage, active when the level-S valid bit is set and `en` = 1:
  - `t = acc + sext(tree)`, computed at ACC_W+1 bits.
  - Signed overflow: t does not fit ACC_W.
  - Not last: `acc <= fit(t)` and `ovf_acc <= ovf_acc | overflow`.
  - Last: `out_sum <= fit(t)`, `out_ovf <= ovf_acc | overflow`, `out_valid <= 1`, `acc <= 0`, `ovf_acc <= 0`.
- `fit()` behaviour depends on the configuration (see below).
- Output handshake: when `out_valid && out_ready` and no new total arrives, `out_valid <= 0`. A new total arriving in the same cycle replaces the old one and `out_valid` stays 1.
- Bubbles: cycles with `in_valid` = 0 inject invalid slots. They never modify `acc`.
- A single-beat packet (`in_last` on the first beat) yields the tree sum of that beat.
- Back-to-back packets run with no bubble. The beat following a last beat starts from `acc` = 0.
- Reset, including mid-packet: all valid bits 0, `acc` 0, `ovf_acc` 0, `out_sum` 0, `out_ovf` 0, `out_valid` 0. Partial packets are discarded. `in_ready` reads 1 while in reset.

## Timing
- Latency: a last beat accepted in cycle c gives `out_valid` = 1 in cycle c+S+1 with no stalls (S = log2(LANES)). For LANES = 8 this is 4 cycles.
- Throughput: one beat per cycle while `out_ready` = 1 or `out_valid` = 0.
- Each stall cycle delays all in-flight beats by exactly one cycle.
- No combinational path from `in_*` to `out_*`. The only combinational path is `out_ready` → `in_ready`.

## Configuration
- `ADD_TREE_SAT_EN` defined: `fit()` saturates to 2^(ACC_W-1)-1 or -2^(ACC_W-1). The accumulator then stays clamped for the rest of the packet.
- `ADD_TREE_SAT_EN` undefined: `fit()` wraps modulo 2^ACC_W, two's complement.
- `out_ovf` is reported identically in both modes.

## Structure
- Shared package `npu_add_pkg`:
  - `clog2` function
  - derived constant S
  - packed lane-vector typedef
  - default parameter values, shared with the MAC array
- Sub-module `add_tree_level`: one registered pairwise-add level with valid/last pass-through and enable. It is instantiated S times by generate.
- The accumulate stage and the output register live in the top module.

## Test plan
Defaults: LANES = 8, IN_W = 8.
- Latency: all lanes = 1, `in_last` = 1, accepted in cycle 0, `out_ready` = 1 → `out_valid` in cycle 4, `out_sum` = 8, `out_ovf` = 0.
- Negative / sign extension: all lanes = -128, single beat → `out_sum` = -1024.
- Accumulation:
  - packet of 3 beats, lanes = 0..7 on each beat → `out_sum` = 84;
  - next packet of one beat, all lanes = 2, sent back-to-back → `out_sum` = 16, delivered in the very next cycle.
- Backpressure: `out_ready` = 0 while 2 packets are in flight → `in_ready` = 0, first total held stable. Raising `out_ready` delivers both totals in order, neither lost nor duplicated.
- Overflow (ACC_W = 12): 3 beats of all lanes = 127 (raw total 3048) → wrap build gives `out_sum` = -1048, `out_ovf` = 1; `ADD_TREE_SAT_EN` build gives `out_sum` = 2047, `out_ovf` = 1.
- Reset mid-packet: assert `rst_n` low after 2 non-last beats, release, then send one beat of all lanes = 1 with last → `out_sum` = 8. All outputs read 0 during reset.

Source files
------------

// File: rtl/npu_add_pkg.sv
// rtl/npu_add_pkg.sv - shared constants, clog2 and lane-vector type for the NPU adder datapath
package npu_add_pkg;
  localparam int LANES_DEF = 8;
  localparam int IN_W_DEF  = 8;
  localparam int ACC_W_DEF = 24;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int S_DEF = clog2(LANES_DEF);

  typedef logic [LANES_DEF*IN_W_DEF-1:0] lane_vec_t;
endpackage

// File: rtl/add_tree_level.sv
// rtl/add_tree_level.sv - one registered pairwise-add level of the lane reduction tree
// Each output is the sign-extended sum of two adjacent inputs, so it never overflows.
module add_tree_level #(
  parameter int N_IN = 8,
  parameter int W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [N_IN*W-1:0]         in_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [(N_IN/2)*(W+1)-1:0] out_data
);
  localparam int N_OUT = N_IN / 2;

  logic                   valid_d, valid_q;
  logic                   last_d, last_q;
  logic [N_OUT*(W+1)-1:0] sum_d, sum_q;

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    sum_d   = sum_q;
    if (en) begin
      valid_d = in_valid;
      last_d  = in_last;
      for (int i = 0; i < N_OUT; i++) begin
        sum_d[i*(W+1) +: W+1] = {in_data[2*i*W + W-1], in_data[2*i*W +: W]}
                              + {in_data[(2*i+1)*W + W-1], in_data[(2*i+1)*W +: W]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_data  = sum_q;
endmodule

// File: rtl/add_tree_acc.sv
// rtl/add_tree_acc.sv - pipelined multi-lane signed adder tree with per-packet accumulation
// Define ADD_TREE_SAT_EN for a saturating accumulator; otherwise it wraps two's complement.
module add_tree_acc
  import npu_add_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_sum,
  output logic                  out_ovf
);
  localparam int S  = clog2(LANES);
  localparam int TW = IN_W + S;

  logic             en;
  logic [TW-1:0]    tree_sum;
  logic             tree_valid, tree_last;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             ovf_acc_d, ovf_acc_q;
  logic [ACC_W-1:0] out_sum_d, out_sum_q;
  logic             out_ovf_d, out_ovf_q;
  logic             out_valid_d, out_valid_q;
  logic [ACC_W:0]   t;
  logic             ovf;
  logic [ACC_W-1:0] fit_t;

  // One enable stalls the whole pipe, so in-flight beats keep their spacing.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  for (genvar j = 0; j < S; j++) begin : g_lvl
    localparam int NI = LANES >> j;
    localparam int WI = IN_W + j;
    logic [NI*WI-1:0]         din;
    logic                     vin, lin;
    logic [(NI/2)*(WI+1)-1:0] dout;
    logic                     vout, lout;
    if (j == 0) begin : g_src
      assign din = in_data;
      assign vin = in_valid;
      assign lin = in_last;
    end else begin : g_src
      assign din = g_lvl[j-1].dout;
      assign vin = g_lvl[j-1].vout;
      assign lin = g_lvl[j-1].lout;
    end
    add_tree_level #(.N_IN(NI), .W(WI)) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (vin),
      .in_last  (lin),
      .in_data  (din),
      .out_valid(vout),
      .out_last (lout),
      .out_data (dout)
    );
  end

  assign tree_sum   = g_lvl[S-1].dout;
  assign tree_valid = g_lvl[S-1].vout;
  assign tree_last  = g_lvl[S-1].lout;

  always_comb begin
    t   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-TW){tree_sum[TW-1]}}, tree_sum};
    ovf = t[ACC_W] ^ t[ACC_W-1];
`ifdef ADD_TREE_SAT_EN
    // Once clamped, the accumulator holds the rail until the packet ends.
    if (ovf_acc_q) begin
      fit_t = acc_q;
    end else if (ovf) begin
      fit_t = t[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      fit_t = t[ACC_W-1:0];
    end
`else
    fit_t = t[ACC_W-1:0];
`endif
  end

  always_comb begin
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (en) begin
      out_valid_d = tree_valid && tree_last;
      if (tree_valid) begin
        if (tree_last) begin
          out_sum_d = fit_t;
          out_ovf_d = ovf_acc_q | ovf;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
        end else begin
          acc_d     = fit_t;
          ovf_acc_d = ovf_acc_q | ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
endmodule
